// File: rtl/edge_propagator_rx.sv
// ----------------------------------------------------------------------------
// edge_propagator_rx
// Receive end of the valid/ack edge-propagation protocol. The transmitter's
// level-held valid is synchronised into clk_i and mirrored back as ack. Each
// rising edge of the synchronised valid is one event. Events queue in a
// saturating pending counter and drain on a valid/ready interface. A sticky
// flag records events lost to saturation.
//
// Ports:
//   clk_i           receive-domain clock
//   rstn_i          asynchronous active-low reset
//   valid_i         asynchronous level from the transmitter (synchroniser only)
//   ack_o           synchronised valid, returned to the transmitter (flop)
//   event_valid_o   at least one event pending (flop)
//   event_ready_i   downstream consumes one event with event_valid_o
//   pending_o       pending-event count (flop)
//   overflow_o      sticky: event dropped at saturation (flop)
//   clr_overflow_i  synchronous clear of overflow_o
// ----------------------------------------------------------------------------
module edge_propagator_rx #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_WIDTH   = 4
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 valid_i,
    output logic                 ack_o,
    output logic                 event_valid_o,
    input  logic                 event_ready_i,
    output logic [CNT_WIDTH-1:0] pending_o,
    output logic                 overflow_o,
    input  logic                 clr_overflow_i
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    // Parameter legality checks at elaboration
    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("edge_propagator_rx: SYNC_STAGES must be >= 2");
        end
        if (CNT_WIDTH < 1) begin : g_bad_cnt
            $error("edge_propagator_rx: CNT_WIDTH must be >= 1");
        end
    endgenerate

    // Synchroniser flops: plain shift chain, no logic between stages
    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] r_sync;

    logic                 r_prev;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_evt_valid;
    logic                 r_ovf;

    logic                 w_sync;
    logic                 w_edge;
    logic                 w_pop;
    logic                 w_full;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;
    logic                 w_ovf_set;

    // Synchroniser chain for the asynchronous valid level
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], valid_i};
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];
    assign w_edge = w_sync & ~r_prev;
    assign w_pop  = r_evt_valid & event_ready_i;
    assign w_full = (r_cnt == CNT_MAX);

    // Counter next-state: simultaneous push and pop cancel, even when full
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_ovf_set = 1'b0;
        case ({w_edge, w_pop})
            2'b10: begin
                if (w_full) begin
                    w_ovf_set = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
                end
            end
            2'b01: begin
                w_cnt_nxt = r_cnt - CNT_WIDTH'(1);
            end
            default: begin
                w_cnt_nxt = r_cnt;
            end
        endcase
    end

    // Edge history, counter, registered valid and sticky overflow
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_prev      <= 1'b0;
            r_cnt       <= '0;
            r_evt_valid <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_prev      <= w_sync;
            r_cnt       <= w_cnt_nxt;
            // Registered copy of (count != 0) keeps ready out of the valid path
            r_evt_valid <= (w_cnt_nxt != '0);
            // Set wins over a same-cycle clear
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (clr_overflow_i) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign ack_o         = w_sync;
    assign event_valid_o = r_evt_valid;
    assign pending_o     = r_cnt;
    assign overflow_o    = r_ovf;

endmodule
